// File: rtl/stage_f_pkg.sv
// Shared types and helpers for the fetch stage: default widths, the fetch-queue
// entry layout and the PC increment used for both fetch and decode.
package stage_f_pkg;

  localparam int                  XLEN_DEF      = 32;
  localparam logic [XLEN_DEF-1:0] RESET_VEC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
  } fetchq_entry_t;

  function automatic logic [XLEN_DEF-1:0] pc_plus4(input logic [XLEN_DEF-1:0] pc);
    return pc + {{(XLEN_DEF-3){1'b0}}, 3'b100};
  endfunction

endpackage

// File: rtl/stage_f_fetchq_fifo.sv
// Generic power-of-two FIFO with synchronous clear; read/write pointers carry an
// extra wrap bit so that full and empty are distinguished without a separate counter.
module fetchq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clear,
  input  logic                 i_push,
  input  logic [W-1:0]         i_din,
  input  logic                 i_pop,
  output logic [W-1:0]         o_dout,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                 o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_full;
  logic         w_do_push;
  logic         w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_count   = r_wptr - r_rptr;
  assign w_do_pop  = i_pop && !o_empty && !i_clear;
  // A full FIFO may still take a push when the head leaves in the same cycle.
  assign w_do_push = i_push && (!w_full || w_do_pop) && !i_clear;
  assign o_dout    = r_mem[r_rptr[AW-1:0]];

  // Pointer update; clear empties the FIFO and overrides push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= {(AW+1){1'b0}};
      r_rptr <= {(AW+1){1'b0}};
    end else if (i_clear) begin
      r_wptr <= {(AW+1){1'b0}};
      r_rptr <= {(AW+1){1'b0}};
    end else begin
      if (w_do_push) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (w_do_pop)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage is intentionally not reset; contents are only observed behind the pointers.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

  fetchq_fifo_chk u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (i_push),
    .i_pop  (w_do_pop),
    .i_clear(i_clear),
    .i_full (w_full)
  );
endmodule

// Overflow checker: upstream credit accounting must never push into a full FIFO.
module fetchq_fifo_chk (
  input logic clk,
  input logic rst_n,
  input logic i_push,
  input logic i_pop,
  input logic i_clear,
  input logic i_full
);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && i_full && !i_pop && !i_clear))
    else $error("fetchq_fifo push while full");
endmodule

// File: rtl/stage_f_fetchq.sv
// Fetch stage: PC register, credit-limited instruction-memory requests and an in-order
// fetch queue feeding decode. Redirects empty the queue and discard in-flight responses.
module stage_f_fetchq
  import stage_f_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_VEC = RESET_VEC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            arm,
  input  logic            PCSrcW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            BranchTakenE,
  input  logic [XLEN-1:0] ALUResultE,
  input  logic            RVPCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            IReqValid,
  output logic [XLEN-1:0] IReqAddr,
  input  logic            IReqReady,
  input  logic            IRespValid,
  input  logic [XLEN-1:0] IRespData,
  output logic            ValidD,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  input  logic            StallD,
  input  logic            FlushD,
  output logic [XLEN-1:0] PCF
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = $bits(fetchq_entry_t);

  logic [XLEN-1:0] r_pcf;
  logic [CW-1:0]   r_drop;
  logic            w_redirect;
  logic [XLEN-1:0] w_target;
  logic [CW-1:0]   w_q_count;
  logic [CW-1:0]   w_pend_count;
  logic [CW:0]     w_used;
  logic [CW-1:0]   w_out_next;
  logic            w_accept;
  logic            w_resp;
  logic            w_q_push;
  logic            w_q_pop;
  logic            w_q_empty;
  logic            w_pend_empty;
  logic [XLEN-1:0] w_pend_pc;
  fetchq_entry_t   w_push_entry;
  fetchq_entry_t   w_head;

  // Redirect select: in ARM mode writeback beats execute; RISC-V mode sees only RVPCSrcE.
  always_comb begin
    w_redirect = 1'b0;
    w_target   = r_pcf;
    if (arm) begin
      if (PCSrcW) begin
        w_redirect = 1'b1;
        w_target   = ResultW;
      end else if (BranchTakenE) begin
        w_redirect = 1'b1;
        w_target   = ALUResultE;
      end else begin
        w_redirect = 1'b0;
        w_target   = r_pcf;
      end
    end else begin
      if (RVPCSrcE) begin
        w_redirect = 1'b1;
        w_target   = PCTargetE;
      end else begin
        w_redirect = 1'b0;
        w_target   = r_pcf;
      end
    end
  end

  // The pending-PC FIFO occupancy doubles as the outstanding-request count.
  assign w_used     = {1'b0, w_q_count} + {1'b0, w_pend_count};
  assign IReqValid  = rst_n && !w_redirect && (w_used < (CW+1)'(DEPTH));
  assign w_accept   = IReqValid && IReqReady;
  assign w_resp     = IRespValid && !w_pend_empty;
  assign w_q_push   = w_resp && !w_redirect && (r_drop == {CW{1'b0}});
  assign ValidD     = !w_q_empty;
  assign w_q_pop    = ValidD && (!StallD || FlushD) && !w_redirect;
  assign w_out_next = w_pend_count + CW'(w_accept) - CW'(w_resp);

  assign w_push_entry = '{pc: w_pend_pc, instr: IRespData};

  // Fetch PC and the number of in-flight responses still to be discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcf  <= RESET_VEC;
      r_drop <= {CW{1'b0}};
    end else if (w_redirect) begin
      r_pcf  <= w_target;
      r_drop <= w_out_next;
    end else begin
      if (w_accept) r_pcf <= pc_plus4(r_pcf);
      if (w_resp && (r_drop != {CW{1'b0}})) r_drop <= r_drop - {{(CW-1){1'b0}}, 1'b1};
    end
  end

  fetchq_fifo #(.DEPTH(DEPTH), .W(XLEN)) u_pend (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clear(1'b0),
    .i_push (w_accept),
    .i_din  (r_pcf),
    .i_pop  (w_resp),
    .o_dout (w_pend_pc),
    .o_count(w_pend_count),
    .o_empty(w_pend_empty)
  );

  fetchq_fifo #(.DEPTH(DEPTH), .W(EW)) u_queue (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clear(w_redirect),
    .i_push (w_q_push),
    .i_din  (w_push_entry),
    .i_pop  (w_q_pop),
    .o_dout (w_head),
    .o_count(w_q_count),
    .o_empty(w_q_empty)
  );

  assign IReqAddr = r_pcf;
  assign PCF      = r_pcf;
  assign InstrD   = w_head.instr;
  assign PCD      = w_head.pc;
  assign PCPlus4D = pc_plus4(w_head.pc);
endmodule

// File: tb/tb_stage_f_fetchq.sv
// Bench for stage_f_fetchq: directed scenarios then random traffic, with every cycle
// compared against a queue-based model of in-flight requests and the decode queue.
module tb_stage_f_fetchq;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RVEC  = 32'h0000_0000;
  localparam logic [31:0] INV   = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm, PCSrcW, BranchTakenE, RVPCSrcE;
  logic [31:0] ResultW, ALUResultE, PCTargetE;
  logic        IReqValid, IReqReady, IRespValid;
  logic [31:0] IReqAddr, IRespData;
  logic        ValidD, StallD, FlushD;
  logic [31:0] InstrD, PCD, PCPlus4D, PCF;

  always #5 clk = ~clk;

  stage_f_fetchq #(.XLEN(32), .DEPTH(DEPTH), .RESET_VEC(RVEC)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .PCSrcW(PCSrcW), .ResultW(ResultW),
    .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE), .RVPCSrcE(RVPCSrcE),
    .PCTargetE(PCTargetE), .IReqValid(IReqValid), .IReqAddr(IReqAddr),
    .IReqReady(IReqReady), .IRespValid(IRespValid), .IRespData(IRespData),
    .ValidD(ValidD), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .StallD(StallD), .FlushD(FlushD), .PCF(PCF)
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] pc; bit stale; } fl_t;
  typedef struct { logic [31:0] addr; int cyc; } mreq_t;

  ent_t        m_q[$];
  fl_t         m_fl[$];
  mreq_t       mem_q[$];
  logic [31:0] m_pcf;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  bit          mem_hold = 1'b0;
  bit          mem_rand = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_fl.delete();
    mem_q.delete();
    m_pcf = RVEC;
  endtask

  task automatic no_redirect();
    PCSrcW = 1'b0; BranchTakenE = 1'b0; RVPCSrcE = 1'b0; FlushD = 1'b0;
  endtask

  task automatic rand_inputs();
    IReqReady    = ($urandom_range(0, 3) != 0);
    StallD       = ($urandom_range(0, 1) != 0);
    FlushD       = ($urandom_range(0, 9) == 0);
    arm          = ($urandom_range(0, 1) != 0);
    PCSrcW       = ($urandom_range(0, 19) == 0);
    BranchTakenE = ($urandom_range(0, 19) == 0);
    RVPCSrcE     = ($urandom_range(0, 19) == 0);
    ResultW      = $urandom & 32'hFFFF_FFFC;
    ALUResultE   = $urandom & 32'hFFFF_FFFC;
    PCTargetE    = $urandom & 32'hFFFF_FFFC;
  endtask

  // One clock: memory drives a response, outputs are checked at the falling edge,
  // then memory and model advance past the rising edge.
  task automatic cycle();
    bit          red, expv, acc, dut_acc, resp, do_pop, keep;
    logic [31:0] tgt, dut_addr;
    fl_t         r;
    keep = 1'b0;
    if (!mem_hold && mem_q.size() > 0 && mem_q[0].cyc < cyc &&
        (!mem_rand || $urandom_range(0, 3) != 0)) begin
      IRespValid = 1'b1;
      IRespData  = mem_q[0].addr ^ INV;
    end else begin
      IRespValid = 1'b0;
      IRespData  = $urandom;
    end
    @(negedge clk);
    red  = arm ? (PCSrcW || BranchTakenE) : RVPCSrcE;
    tgt  = arm ? (PCSrcW ? ResultW : ALUResultE) : PCTargetE;
    expv = !red && ((m_q.size() + m_fl.size()) < DEPTH);
    acc  = expv && IReqReady;
    chk("PCF", PCF, m_pcf);
    chk("IReqValid", {31'b0, IReqValid}, {31'b0, expv});
    if (expv) chk("IReqAddr", IReqAddr, m_pcf);
    chk("ValidD", {31'b0, ValidD}, {31'b0, (m_q.size() != 0)});
    if (m_q.size() != 0) begin
      chk("PCD", PCD, m_q[0].pc);
      chk("InstrD", InstrD, m_q[0].instr);
      chk("PCPlus4D", PCPlus4D, m_q[0].pc + 32'd4);
    end
    dut_acc  = IReqValid && IReqReady;
    dut_addr = IReqAddr;
    resp     = IRespValid;
    do_pop   = (m_q.size() != 0) && (!StallD || FlushD);
    @(posedge clk);
    if (resp) mem_q.delete(0);
    if (dut_acc) mem_q.push_back('{addr: dut_addr, cyc: cyc});
    cyc++;
    if (resp && m_fl.size() != 0) begin
      r    = m_fl.pop_front();
      keep = !r.stale && !red;
    end
    if (red) begin
      m_q.delete();
      foreach (m_fl[i]) m_fl[i].stale = 1'b1;
      m_pcf = tgt;
    end else begin
      if (do_pop) m_q.delete(0);
      if (keep) m_q.push_back('{pc: r.pc, instr: r.pc ^ INV});
      if (acc) begin
        m_fl.push_back('{pc: m_pcf, stale: 1'b0});
        m_pcf = m_pcf + 32'd4;
      end
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; ResultW = 32'h0; ALUResultE = 32'h0; PCTargetE = 32'h0;
    no_redirect();
    IReqReady = 1'b1; IRespValid = 1'b0; IRespData = 32'h0; StallD = 1'b0;
    model_reset();
    #2;
    chk("rst_IReqValid", {31'b0, IReqValid}, 32'd0);
    chk("rst_ValidD", {31'b0, ValidD}, 32'd0);
    chk("rst_PCF", PCF, RVEC);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Streaming fetch: decode sees the first entry two cycles after the first accept.
    cycle(); cycle();
    chk("first_ValidD", {31'b0, ValidD}, 32'd1);
    chk("first_PCD", PCD, 32'h0);
    chk("first_PCPlus4D", PCPlus4D, 32'h4);
    chk("third_IReqAddr", IReqAddr, 32'h8);

    // Decode stalled: exactly DEPTH requests, then no credit; then drain in order.
    StallD = 1'b1;
    repeat (8) cycle();
    chk("stall_IReqValid", {31'b0, IReqValid}, 32'd0);
    chk("stall_PCD", PCD, 32'h0);
    chk("stall_PCF", PCF, 32'h10);
    StallD = 1'b0;
    repeat (6) cycle();

    // RISC-V redirect with requests in flight: their responses are dropped.
    mem_hold = 1'b1;
    repeat (2) cycle();
    mem_hold = 1'b0;
    arm = 1'b0; RVPCSrcE = 1'b1; PCTargetE = 32'h1000;
    cycle();
    no_redirect();
    chk("rv_redir_PCF", PCF, 32'h1000);
    chk("rv_redir_ValidD", {31'b0, ValidD}, 32'd0);
    repeat (8) cycle();

    // ARM priority, then the same ARM inputs ignored in RISC-V mode.
    arm = 1'b1; PCSrcW = 1'b1; ResultW = 32'h2000; BranchTakenE = 1'b1; ALUResultE = 32'h3000;
    cycle();
    chk("arm_prio_PCF", PCF, 32'h2000);
    arm = 1'b0;
    cycle();
    no_redirect();
    repeat (4) cycle();

    // Full queue: FlushD kills the head under StallD; redirect overrides FlushD.
    StallD = 1'b1;
    repeat (12) cycle();
    chk("full_IReqValid", {31'b0, IReqValid}, 32'd0);
    FlushD = 1'b1;
    cycle();
    FlushD = 1'b0;
    cycle();
    arm = 1'b0; RVPCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC; FlushD = 1'b1;
    cycle();
    no_redirect();
    chk("redir_flush_ValidD", {31'b0, ValidD}, 32'd0);
    chk("redir_flush_PCF", PCF, 32'hFFFF_FFFC);

    // PC wrap at the top of the address space.
    StallD = 1'b0;
    cycle();
    chk("wrap_PCF", PCF, 32'h0);
    cycle();
    chk("wrap_PCD", PCD, 32'hFFFF_FFFC);
    chk("wrap_PCPlus4D", PCPlus4D, 32'h0);
    repeat (4) cycle();

    // Random traffic with random memory latency.
    mem_rand = 1'b1;
    repeat (1500) begin
      rand_inputs();
      cycle();
    end

    // Reset in the middle of a burst; memory is reset with the block.
    no_redirect(); StallD = 1'b0; IReqReady = 1'b1; mem_rand = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b0;
    IRespValid = 1'b0;
    #1;
    chk("midrst_IReqValid", {31'b0, IReqValid}, 32'd0);
    chk("midrst_ValidD", {31'b0, ValidD}, 32'd0);
    chk("midrst_PCF", PCF, RVEC);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) cycle();
    mem_rand = 1'b1;
    repeat (300) begin
      rand_inputs();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
